// File: rtl/mul_arb_pkg.sv
// Shared constants and tag record for the multiply-cell arbiter.
package mul_arb_pkg;

  localparam int DATA_W          = 32;
  localparam int CNT_W           = 16;
  localparam int MUL_LAT_DEFAULT = 1;

  // Tag index is sized for the largest supported requester count (8),
  // so one record type serves every NUM_REQ in the 2..8 range.
  localparam int TAG_IDX_W = 3;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first set request at or above ptr, wrapping to bit 0.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic [NUM_REQ-1:0] upper_mask_s;
  logic [NUM_REQ-1:0] upper_req_s;
  logic [NUM_REQ-1:0] pick_s;

  // Prefer requests at or above the pointer; otherwise wrap to the lowest one
  always_comb begin
    upper_mask_s = ~((NUM_REQ'(1'b1) << ptr) - NUM_REQ'(1'b1));
    upper_req_s  = req & upper_mask_s;
    if (|upper_req_s) begin
      pick_s = upper_req_s;
    end else begin
      pick_s = req;
    end
    // Isolate the lowest set bit of the chosen vector
    grant = pick_s & (~pick_s + NUM_REQ'(1'b1));
  end

endmodule

// File: rtl/mul_cell_arbiter.sv
// Shares one external multiply cell among NUM_REQ requesters with
// round-robin issue and an in-order tag pipeline for result routing.
module mul_cell_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_src1,
  input  logic [NUM_REQ*DATA_W-1:0] req_src2,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         mul_src1,
  output logic [DATA_W-1:0]         mul_src2,
  input  logic [DATA_W-1:0]         mul_cell_result,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      idle,
  output logic [CNT_W-1:0]          issue_count
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] grant_s;
  logic               accept_s;
  logic [PTR_W-1:0]   grant_idx_s;
  logic [DATA_W-1:0]  sel_src1_s, sel_src2_s;
  logic [DATA_W-1:0]  mul_src1_q, mul_src1_d;
  logic [DATA_W-1:0]  mul_src2_q, mul_src2_d;
  tag_t               tag_q [MUL_LAT+1];
  tag_t               tag_d [MUL_LAT+1];
  logic               tags_busy_s;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_result_q, rsp_result_d;
  logic [CNT_W-1:0]   issue_count_q, issue_count_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant_s)
  );

  // Grant is withheld while reset is asserted so nothing is accepted then
  always_comb begin
    if (reset) begin
      req_ready = '0;
    end else begin
      req_ready = grant_s;
    end
    accept_s = |(req_valid & req_ready);
  end

  // Encode the one-hot grant and mux out the granted operands
  always_comb begin
    grant_idx_s = '0;
    sel_src1_s  = '0;
    sel_src2_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_idx_s = grant_idx_s | (grant_s[i] ? PTR_W'(i) : PTR_W'(0));
      sel_src1_s  = sel_src1_s | (req_src1[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
      sel_src2_s  = sel_src2_s | (req_src2[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
    end
  end

  // Pointer advance, operand capture and saturating issue counter on accept
  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    mul_src1_d    = mul_src1_q;
    mul_src2_d    = mul_src2_q;
    issue_count_d = issue_count_q;
    if (accept_s) begin
      if (grant_idx_s == PTR_W'(NUM_REQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx_s + PTR_W'(1);
      end
      mul_src1_d = sel_src1_s;
      mul_src2_d = sel_src2_s;
      if (issue_count_q == {CNT_W{1'b1}}) begin
        issue_count_d = issue_count_q;
      end else begin
        issue_count_d = issue_count_q + CNT_W'(1);
      end
    end else begin
      rr_ptr_d      = rr_ptr_q;
      issue_count_d = issue_count_q;
    end
  end

  // Tag pipeline shadows the cell; its last stage routes the returning product
  always_comb begin
    tag_d[0].valid = accept_s;
    tag_d[0].idx   = TAG_IDX_W'(grant_idx_s);
    for (int k = 1; k <= MUL_LAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end
    rsp_valid_d  = '0;
    rsp_result_d = rsp_result_q;
    if (tag_q[MUL_LAT].valid) begin
      rsp_valid_d  = NUM_REQ'(1'b1) << tag_q[MUL_LAT].idx;
      rsp_result_d = mul_cell_result;
    end else begin
      rsp_valid_d  = '0;
      rsp_result_d = rsp_result_q;
    end
    tags_busy_s = 1'b0;
    for (int k = 0; k <= MUL_LAT; k++) begin
      tags_busy_s = tags_busy_s | tag_q[k].valid;
    end
  end

  // State registers; reset drops every in-flight tag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q      <= '0;
      mul_src1_q    <= '0;
      mul_src2_q    <= '0;
      rsp_valid_q   <= '0;
      rsp_result_q  <= '0;
      issue_count_q <= '0;
      for (int k = 0; k <= MUL_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      mul_src1_q    <= mul_src1_d;
      mul_src2_q    <= mul_src2_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      issue_count_q <= issue_count_d;
      for (int k = 0; k <= MUL_LAT; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign mul_src1    = mul_src1_q;
  assign mul_src2    = mul_src2_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign issue_count = issue_count_q;
  assign idle        = ~tags_busy_s & ~accept_s;

endmodule

// File: tb/tb_mul_cell_arbiter.sv
// Self-checking bench for mul_cell_arbiter with a behavioural multiply cell
// and a queue-based reference model of grants and in-order responses.
module tb_mul_cell_arbiter;

  localparam int N = 4;

  logic          clk;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N*32-1:0] req_src1;
  logic [N*32-1:0] req_src2;
  logic [N-1:0]  req_ready;
  logic [31:0]   mul_src1;
  logic [31:0]   mul_src2;
  logic [31:0]   mul_cell_result;
  logic [N-1:0]  rsp_valid;
  logic [31:0]   rsp_result;
  logic          idle;
  logic [15:0]   issue_count;

  mul_cell_arbiter #(.NUM_REQ(N), .MUL_LAT(1)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_src1        (req_src1),
    .req_src2        (req_src2),
    .req_ready       (req_ready),
    .mul_src1        (mul_src1),
    .mul_src2        (mul_src2),
    .mul_cell_result (mul_cell_result),
    .rsp_valid       (rsp_valid),
    .rsp_result      (rsp_result),
    .idle            (idle),
    .issue_count     (issue_count)
  );

  // External multiply cell: one registered stage
  logic [31:0] cell_q;
  always @(posedge clk) cell_q <= mul_src1 * mul_src2;
  assign mul_cell_result = cell_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  typedef struct { int idx; logic [31:0] res; int due; } exp_t;
  exp_t        exp_q[$];
  int          model_ptr;
  int          edge_cnt;
  int          acc_idx;
  logic [15:0] model_cnt;
  logic [31:0] model_last, model_a, model_b;
  logic [N-1:0] pend;
  logic [31:0] opa [N];
  logic [31:0] opb [N];
  logic [N-1:0] exp_ready, obs_ready, exp_rv;
  logic        exp_idle, obs_idle;
  logic [31:0] exp_rr;

  // Winner = pending requester with the smallest forward distance from the pointer
  function automatic int model_pick(input logic [N-1:0] v, input int p);
    int best;
    int bestd;
    best  = -1;
    bestd = N;
    for (int k = 0; k < N; k++) begin
      if (v[k]) begin
        int d;
        d = (k - p + N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = k;
        end
      end
    end
    return best;
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    pend[i] = 1'b1;
    opa[i]  = a;
    opb[i]  = b;
  endtask

  task automatic model_clear();
    exp_q.delete();
    model_ptr  = 0;
    model_cnt  = 16'h0000;
    model_last = 32'h0;
    model_a    = 32'h0;
    model_b    = 32'h0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    pend      = '0;
    req_valid = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  // Drive pending requests for one cycle, advance the model across the edge
  task automatic step();
    int pick;
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = pend[i];
      req_src1[i*32 +: 32]  = opa[i];
      req_src2[i*32 +: 32]  = opb[i];
    end
    #2;
    pick      = model_pick(req_valid, model_ptr);
    exp_ready = (pick >= 0) ? (N'(1) << pick) : '0;
    exp_idle  = (exp_q.size() == 0) && (pick < 0);
    obs_ready = req_ready;
    obs_idle  = idle;
    @(posedge clk);
    edge_cnt++;
    acc_idx = pick;
    if (pick >= 0) begin
      exp_q.push_back('{idx: pick, res: opa[pick] * opb[pick], due: edge_cnt + 2});
      model_ptr = (pick + 1) % N;
      if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
      model_a    = opa[pick];
      model_b    = opb[pick];
      pend[pick] = 1'b0;
    end
    exp_rv = '0;
    exp_rr = model_last;
    if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
      exp_rv     = N'(1) << exp_q[0].idx;
      exp_rr     = exp_q[0].res;
      model_last = exp_q[0].res;
      void'(exp_q.pop_front());
    end
    #1;
  endtask

  task automatic test_reset();
    req_valid = 4'hF;
    @(posedge clk);
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b exp=1", idle); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
    checks++; if (rsp_result !== 32'h0) begin errors++; $display("FAIL reset_rsp_result got=%h exp=0", rsp_result); end
    checks++; if (mul_src1 !== 32'h0 || mul_src2 !== 32'h0) begin errors++; $display("FAIL reset_mul_src got=%h/%h exp=0/0", mul_src1, mul_src2); end
    checks++; if (issue_count !== 16'h0) begin errors++; $display("FAIL reset_count got=%h exp=0", issue_count); end
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 32'd3, 32'd5);
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL single_ready c=%0d got=%b exp=%b", c, obs_ready, exp_ready); end
      checks++; if (rsp_valid !== exp_rv || rsp_result !== exp_rr) begin errors++; $display("FAIL single_rsp c=%0d got=%b/%h exp=%b/%h", c, rsp_valid, rsp_result, exp_rv, exp_rr); end
      if (c == 0) begin
        checks++; if (obs_ready !== 4'b0001) begin errors++; $display("FAIL single_grant got=%b exp=0001", obs_ready); end
        checks++; if (mul_src1 !== 32'd3 || mul_src2 !== 32'd5) begin errors++; $display("FAIL single_mul_src got=%h/%h exp=3/5", mul_src1, mul_src2); end
      end
      if (c == 2) begin
        checks++; if (rsp_valid !== 4'b0001 || rsp_result !== 32'd15) begin errors++; $display("FAIL single_result got=%b/%0d exp=0001/15", rsp_valid, rsp_result); end
      end
    end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle got=%b exp=1", idle); end
  endtask

  task automatic test_wrap();
    logic [N-1:0] want [3];
    want[0] = 4'b0100;
    want[1] = 4'b0010;
    want[2] = 4'b0100;
    do_reset();
    set_req(2, 32'd7, 32'd9);
    for (int c = 0; c < 6; c++) begin
      if (c == 1 || c == 2) begin
        set_req(1, $urandom, $urandom);
        set_req(2, $urandom, $urandom);
      end
      step();
      if (c < 3) begin
        checks++; if (obs_ready !== want[c]) begin errors++; $display("FAIL wrap_grant c=%0d got=%b exp=%b", c, obs_ready, want[c]); end
      end
      checks++; if (rsp_valid !== exp_rv || rsp_result !== exp_rr) begin errors++; $display("FAIL wrap_rsp c=%0d got=%b/%h exp=%b/%h", c, rsp_valid, rsp_result, exp_rv, exp_rr); end
    end
    pend = '0;
  endtask

  task automatic test_overflow();
    do_reset();
    set_req(3, 32'hFFFF_FFFF, 32'd2);
    for (int c = 0; c < 4; c++) begin
      step();
      if (c == 2) begin
        checks++; if (rsp_valid !== 4'b1000 || rsp_result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL overflow got=%b/%h exp=1000/fffffffe", rsp_valid, rsp_result); end
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, $urandom, $urandom);
    for (int c = 0; c < 14; c++) begin
      step();
      if (acc_idx >= 0) set_req(acc_idx, $urandom, $urandom);
      checks++; if (obs_ready !== (N'(1) << (c % N))) begin errors++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, obs_ready, N'(1) << (c % N)); end
      if (c >= 2) begin
        checks++; if (rsp_valid !== (N'(1) << ((c - 2) % N))) begin errors++; $display("FAIL rr_rsp_order c=%0d got=%b exp=%b", c, rsp_valid, N'(1) << ((c - 2) % N)); end
      end
      checks++; if (rsp_result !== exp_rr) begin errors++; $display("FAIL rr_result c=%0d got=%h exp=%h", c, rsp_result, exp_rr); end
    end
    pend = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 45) begin
          set_req(i, ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom, $urandom);
        end
      end
      if (c >= 290) pend = '0;
      step();
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, obs_ready, exp_ready); end
      checks++; if (obs_idle !== exp_idle) begin errors++; $display("FAIL rand_idle c=%0d got=%b exp=%b", c, obs_idle, exp_idle); end
      checks++; if (rsp_valid !== exp_rv || rsp_result !== exp_rr) begin errors++; $display("FAIL rand_rsp c=%0d got=%b/%h exp=%b/%h", c, rsp_valid, rsp_result, exp_rv, exp_rr); end
      checks++; if (mul_src1 !== model_a || mul_src2 !== model_b) begin errors++; $display("FAIL rand_mul_src c=%0d got=%h/%h exp=%h/%h", c, mul_src1, mul_src2, model_a, model_b); end
      checks++; if (issue_count !== model_cnt) begin errors++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, issue_count, model_cnt); end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    set_req(0, 32'd11, 32'd13);
    set_req(1, 32'd17, 32'd19);
    step();
    step();
    reset = 1'b1;
    pend  = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    for (int c = 0; c < 6; c++) begin
      step();
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL midreset_rsp c=%0d got=%b exp=0000", c, rsp_valid); end
      checks++; if (idle !== 1'b1 || issue_count !== 16'h0) begin errors++; $display("FAIL midreset_state c=%0d got=%b/%h exp=1/0", c, idle, issue_count); end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 1; k <= 65538; k++) begin
      set_req(0, 32'd1, 32'd1);
      step();
      if (k == 65534) begin
        checks++; if (issue_count !== 16'hFFFE) begin errors++; $display("FAIL sat_before got=%h exp=fffe", issue_count); end
      end
      if (k >= 65535) begin
        checks++; if (issue_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold k=%0d got=%h exp=ffff", k, issue_count); end
      end
    end
    pend = '0;
    step();
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_src1  = '0;
    req_src2  = '0;
    pend      = '0;
    edge_cnt  = 0;
    acc_idx   = -1;
    for (int i = 0; i < N; i++) begin
      opa[i] = 32'h0;
      opb[i] = 32'h0;
    end
    model_clear();
    test_reset();
    test_single();
    test_wrap();
    test_overflow();
    test_round_robin();
    test_random();
    test_reset_midflight();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
